// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined decode-stage immediate generator. Decodes the MIPS opcode/funct
//   of instr_i and produces one operand (SEXT/ZEXT/LUI immediate, branch
//   offset, jump target or shift amount), registered through STAGES stages
//   with stall and flush control.
//
// Parameters
//   DATA_W : output datapath width, 32 or 64
//   STAGES : register stages from input to output, 1..3
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   instr_i     in   [31:0]       instruction word from IF/ID
//   pc_plus4_i  in   [DATA_W-1:0] PC+4 of instr_i
//   valid_i     in   instr_i/pc_plus4_i valid this cycle
//   stall_i     in   hold every stage, input not captured
//   flush_i     in   kill every in-flight entry (wins over stall/valid_i)
//   imm_o       out  [DATA_W-1:0] generated operand
//   kind_o      out  [2:0] 0=SEXT 1=ZEXT 2=LUI 3=BR 4=JMP 5=SHAMT
//   valid_o     out  imm_o/kind_o valid
//   br_target_o out  [DATA_W-1:0] branch target
//
// Optional feature
//   IMM_GEN_BR_TARGET_EN : when defined, stage 1 also computes
//   pc_plus4_i + (sext(imm) << 2) and pipelines it to br_target_o.
//   When undefined, br_target_o is tied to zero.
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] imm_o,
    output logic [2:0]        kind_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] br_target_o
);

    generate
        if (!((DATA_W == 32) || (DATA_W == 64))) begin : g_bad_data_w
            $error("imm_gen_pipe: DATA_W must be 32 or 64");
        end
        if ((STAGES < 1) || (STAGES > 3)) begin : g_bad_stages
            $error("imm_gen_pipe: STAGES must be in 1..3");
        end
    endgenerate

    typedef enum logic [2:0] {
        K_SEXT  = 3'd0,
        K_ZEXT  = 3'd1,
        K_LUI   = 3'd2,
        K_BR    = 3'd3,
        K_JMP   = 3'd4,
        K_SHAMT = 3'd5
    } kind_e;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_br_off;
    kind_e             w_kind;
    logic [DATA_W-1:0] w_imm;

    assign w_op    = instr_i[31:26];
    assign w_funct = instr_i[5:0];
    assign w_imm16 = instr_i[15:0];

    // Every shifted form is derived from the full-width sign extension, so
    // LUI and branch offsets keep their sign bits at DATA_W width.
    assign w_sext   = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
    assign w_br_off = w_sext << 2;

    always_comb begin
        w_kind = K_SEXT;
        w_imm  = w_sext;
        case (w_op)
            6'h0C, 6'h0D, 6'h0E: begin
                w_kind = K_ZEXT;
                w_imm  = {{(DATA_W-16){1'b0}}, w_imm16};
            end
            6'h0F: begin
                w_kind = K_LUI;
                w_imm  = w_sext << 16;
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
                w_kind = K_BR;
                w_imm  = w_br_off;
            end
            6'h02, 6'h03: begin
                w_kind = K_JMP;
                w_imm  = {pc_plus4_i[DATA_W-1:28], instr_i[25:0], 2'b00};
            end
            6'h00: begin
                if ((w_funct == 6'h00) || (w_funct == 6'h02) || (w_funct == 6'h03)) begin
                    w_kind = K_SHAMT;
                    w_imm  = {{(DATA_W-5){1'b0}}, instr_i[10:6]};
                end
            end
            default: begin
                w_kind = K_SEXT;
                w_imm  = w_sext;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers: index 0 is stage 1, STAGES-1 drives the outputs
    // ------------------------------------------------------------------
    logic              r_valid [STAGES];
    kind_e             r_kind  [STAGES];
    logic [DATA_W-1:0] r_imm   [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_kind[i]  <= K_SEXT;
                r_imm[i]   <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_kind[i]  <= K_SEXT;
                r_imm[i]   <= '0;
            end
        end else if (!stall_i) begin
            // Bubbles still capture data; only the valid bit is cleared.
            r_valid[0] <= valid_i;
            r_kind[0]  <= w_kind;
            r_imm[0]   <= w_imm;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_kind[i]  <= r_kind[i-1];
                r_imm[i]   <= r_imm[i-1];
            end
        end
    end

    assign valid_o = r_valid[STAGES-1];
    assign kind_o  = r_kind[STAGES-1];
    assign imm_o   = r_imm[STAGES-1];

`ifdef IMM_GEN_BR_TARGET_EN
    logic [DATA_W-1:0] w_tgt;
    logic [DATA_W-1:0] r_tgt [STAGES];

    // Wraps on overflow; computed for every kind, meaningful only for BR.
    assign w_tgt = pc_plus4_i + w_br_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_tgt[i] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_tgt[i] <= '0;
            end
        end else if (!stall_i) begin
            r_tgt[0] <= w_tgt;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_tgt[i] <= r_tgt[i-1];
            end
        end
    end

    assign br_target_o = r_tgt[STAGES-1];
`else
    // Low PC bits only feed the branch adder; keep them visibly consumed.
    logic w_unused_pc;
    assign w_unused_pc = &{1'b0, pc_plus4_i[27:0]};
    assign br_target_o = '0;
`endif

endmodule
